// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder resolving one SW-bit slice per stage, with valid/ready flow control.
// Optional subtract mode is built when ADDER_SUB_EN is defined; the default build is add-only.
module pipelined_adder #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;

  // Stage k holds a token whose slices below k are resolved, plus the carry into slice k.
  logic [STAGES-1:0]            valid_q,  valid_d;
  logic [STAGES-1:0][WIDTH-1:0] opA_q,    opA_d;
  logic [STAGES-1:0][WIDTH-1:0] opB_q,    opB_d;
  logic [STAGES-1:0][WIDTH-1:0] sumAcc_q, sumAcc_d;
  logic [STAGES-1:0]            carry_q,  carry_d;
`ifdef ADDER_SUB_EN
  logic                         sub_q,    sub_d;
`endif

  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] s_q,        s_d;
  logic             cout_q,     cout_d;
  logic             ovf_q,      ovf_d;

  logic [STAGES-1:0][WIDTH-1:0] opBEff;
  logic [STAGES-1:0]            carryEff;
  logic [STAGES-1:0][SW-1:0]    sliceSum;
  logic [STAGES-1:0]            sliceCarry;
  logic                         adv;

  assign adv      = !outValid_q || out_ready;
  assign in_ready = adv;

  always_comb begin
    opBEff   = opB_q;
    carryEff = carry_q;
`ifdef ADDER_SUB_EN
    if (sub_q) begin
      opBEff[0]   = ~opB_q[0];
      carryEff[0] = carry_q[0] ^ 1'b1;
    end
`endif
    for (int k = 0; k < STAGES; k++) begin
      {sliceCarry[k], sliceSum[k]} = {1'b0, opA_q[k][k*SW +: SW]}
                                   + {1'b0, opBEff[k][k*SW +: SW]}
                                   + {{SW{1'b0}}, carryEff[k]};
    end

    valid_d[0]  = in_valid;
    opA_d[0]    = x;
    opB_d[0]    = y;
    carry_d[0]  = cin;
    sumAcc_d[0] = '0;
`ifdef ADDER_SUB_EN
    sub_d       = sub;
`endif
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k]  = valid_q[k-1];
      opA_d[k]    = opA_q[k-1];
      opB_d[k]    = opBEff[k-1];
      carry_d[k]  = sliceCarry[k-1];
      sumAcc_d[k] = sumAcc_q[k-1];
      sumAcc_d[k][(k-1)*SW +: SW] = sliceSum[k-1];
    end

    outValid_d = valid_q[STAGES-1];
    s_d        = sumAcc_q[STAGES-1];
    s_d[(STAGES-1)*SW +: SW] = sliceSum[STAGES-1];
    cout_d     = sliceCarry[STAGES-1];
    // Equivalent to carry-out xor carry-into-MSB: same-sign operands giving an opposite-sign result.
    ovf_d      = (opA_q[STAGES-1][WIDTH-1] == opBEff[STAGES-1][WIDTH-1])
              && (s_d[WIDTH-1] != opA_q[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      sumAcc_q   <= '0;
      carry_q    <= '0;
`ifdef ADDER_SUB_EN
      sub_q      <= 1'b0;
`endif
      outValid_q <= 1'b0;
      s_q        <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (adv) begin
      valid_q    <= valid_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      sumAcc_q   <= sumAcc_d;
      carry_q    <= carry_d;
`ifdef ADDER_SUB_EN
      sub_q      <= sub_d;
`endif
      outValid_q <= outValid_d;
      s_q        <= s_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid = outValid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two-operand integer adder with carry-in, carry-out and signed-overflow flags. It splits the operands into `STAGES` equal slices and resolves one slice per clock, so a wide add meets timing at one result per cycle after the pipeline fills. Valid/ready handshakes on both sides let it sit between register-sliced datapath stages and apply backpressure through the whole pipeline. It replaces fixed-width combinational ripple adders wherever operand width makes a single-cycle carry chain too slow.

## Interface
- `WIDTH`, 64: operand and sum width in bits. Must be ≥ 2 and divisible by `STAGES`.
- `STAGES`, 4: number of pipeline stages. Must be ≥ 1. Slice width `SW = WIDTH/STAGES`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operands present this cycle.
- `in_ready`  out  1  block accepts operands this cycle.
- `x`  in  WIDTH  operand A.
- `y`  in  WIDTH  operand B.
- `cin`  in  1  carry-in; borrow-in in subtract mode.
- `sub`  in  1  subtract select. Only present when `ADDER_SUB_EN` is defined.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `s`  out  WIDTH  sum or difference.
- `cout`  out  1  carry out of bit WIDTH-1.
- `ovf`  out  1  two's-complement overflow.

## Operation
- Effective B is `y`, or `~y` when subtracting. Effective carry-in is `cin`, or `cin ^ 1` when subtracting.
- Stage k (0..STAGES-1) adds slice k of A and B (bits k·SW+SW-1 : k·SW) plus the carry registered by stage k-1. Stage 0 uses the effective carry-in.
- Slices not yet consumed travel forward in skew registers. Completed sum slices travel forward with the data. After the last stage, all slices are aligned in `s`.
- `cout` is the carry out of the top slice. In subtract mode, `cout` = 1 means no borrow.
- `ovf = c[WIDTH] ^ c[WIDTH-1]`, where `c[WIDTH-1]` is the carry into bit WIDTH-1. It is computed in the last stage.
- Each stage holds a valid bit. Tokens never reorder, merge or drop.
- Global advance: `adv = !out_valid | out_ready`.
- On `adv`:
  - Each stage loads from the stage before it.
  - Stage 0 loads `in_valid` together with the operands.
- When `adv` = 0, every stage register, valid bit and output holds its value.
- `in_ready = adv`. A transfer into the block occurs when `in_valid & in_ready`.
- A bubble (`in_valid` = 0 on `adv`) propagates as an invalid token. Its data contents are don't-care. Its `s`/`cout`/`ovf` are unconstrained while `out_valid` = 0.

## Timing
- Reset (async assert, sync release on first clk edge after deassert): all valid bits, skew/sum/carry registers, `s`, `cout`, `ovf`, `out_valid` = 0. `in_ready` = 1 from the first cycle after reset (it follows from `out_valid` = 0).
- Latency: operands accepted at edge n appear with `out_valid` = 1 after edge n+STAGES, provided there is no stall. With `STAGES` = 1, this is a registered single-cycle adder.
- Throughput: one result per cycle while `out_ready` = 1.
- Stall: `out_valid` = 1 with `out_ready` = 0 freezes the pipeline. `s`/`cout`/`ovf` stay stable until the cycle `out_ready` is seen high.
- Simultaneous events:
  - Input accept and output drain in the same cycle are both legal.
  - Output drain plus an input bubble shifts the pipeline and can leave `out_valid` = 0.
- Reset mid-operation discards all in-flight tokens. No output is produced for them.
- Wrap-around: the sum is modulo 2^WIDTH. Overflow is reported only via `cout`/`ovf`. There is no saturation.

## Configuration
- `ADDER_SUB_EN` defined:
  - The `sub` port exists and travels with its operand through stage 0.
  - `sub` = 1 yields `x - y - cin`, with `cout` = not-borrow and `ovf` = signed subtraction overflow.
- `ADDER_SUB_EN` undefined:
  - The `sub` port is absent and the inversion logic is not built.
  - The block only computes `x + y + cin`.

## Test plan
- WIDTH=64, STAGES=4. `x`=0xFFFF_FFFF_FFFF_FFFF, `y`=0, `cin`=1 -> 4 cycles later `s`=0, `cout`=1, `ovf`=0. This exercises the full carry ripple across every stage boundary.
- `x`=0x7FFF_FFFF_FFFF_FFFF, `y`=1, `cin`=0 -> `s`=0x8000_0000_0000_0000, `cout`=0, `ovf`=1.
- 100 back-to-back random operand pairs with `out_ready`=1 -> 100 consecutive `out_valid` cycles, in order, each matching the reference model `(x+y+cin) mod 2^64`.
- Hold `out_ready`=0 for 5 cycles while the pipeline is full:
  - `in_ready`=0 during the hold and outputs stay frozen.
  - After release, results drain in order with no loss or duplication.
- Assert `rst` for 1 cycle with 3 tokens in flight -> `out_valid` and all outputs are 0 immediately. No stale token ever appears afterwards.
- With `ADDER_SUB_EN` defined: `x`=5, `y`=7, `sub`=1, `cin`=0 -> `s`=0xFFFF_FFFF_FFFF_FFFE, `cout`=0 (borrow), `ovf`=0. Also `x`=7, `y`=5 -> `s`=2, `cout`=1.
